// File: rtl/pipe_ctrl_if.sv
// Bundle of stall-request inputs and stall/redirect outputs shared between the
// pipeline stall/flush controller and the core that feeds it.
interface pipe_ctrl_if #(
  parameter int NREQ   = 5,
  parameter int STAGES = 6,
  parameter int PC_W   = 32,
  parameter int CNT_W  = 32
);
  logic [NREQ-1:0]   stall_req;
  logic              exc_valid;
  logic [PC_W-1:0]   exc_pc;
  logic              cnt_clr;
  logic [STAGES-1:0] stall;
  logic              flush;
  logic [PC_W-1:0]   new_pc;
  logic              exc_pending;
  logic [CNT_W-1:0]  stall_cycles;

  modport master (
    output stall_req, exc_valid, exc_pc, cnt_clr,
    input  stall, flush, new_pc, exc_pending, stall_cycles
  );

  modport slave (
    input  stall_req, exc_valid, exc_pc, cnt_clr,
    output stall, flush, new_pc, exc_pending, stall_cycles
  );
endinterface

// File: rtl/pipe_ctrl_param.sv
// Pipeline stall/flush controller: ORs per-request stall masks, defers CP0
// redirects behind blocking requests, stretches flush and counts stalled cycles.
module pipe_ctrl_param #(
  parameter int                      STAGES    = 6,
  parameter int                      NREQ      = 5,
  parameter logic [NREQ*STAGES-1:0]  REQ_MASKS = {6'b000001, 6'b000101, 6'b001101,
                                                  6'b111111, 6'b111111},
  parameter logic [NREQ-1:0]         EXC_BLOCK = 5'b00010,
  parameter int                      FLUSH_CYC = 1,
  parameter int                      PC_W      = 32,
  parameter int                      CNT_W     = 32
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus
);

  localparam int              FC_W    = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_FLUSH} state_t;

  state_t            r_state;
  logic              r_flush;
  logic              r_exc_pending;
  logic [PC_W-1:0]   r_pc;
  logic [PC_W-1:0]   r_new_pc;
  logic [FC_W-1:0]   r_fcnt;
  logic [CNT_W-1:0]  r_stall_cycles;

  logic [STAGES-1:0] w_stall_or;
  logic [STAGES-1:0] w_stall;
  logic              w_block;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Requests combine by OR of their masks; no priority is needed.
  always_comb begin
    w_stall_or = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (bus.stall_req[i]) begin
        w_stall_or = w_stall_or | REQ_MASKS[i*STAGES +: STAGES];
      end
    end
  end

  assign w_block = |(bus.stall_req & EXC_BLOCK);
  assign w_stall = (rst || r_flush) ? '0 : w_stall_or;

  // Oldest redirect wins: exc_valid is only sampled in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_flush       <= 1'b0;
      r_exc_pending <= 1'b0;
      r_pc          <= '0;
      r_new_pc      <= '0;
      r_fcnt        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.exc_valid) begin
            r_pc <= bus.exc_pc;
            if (w_block) begin
              r_state       <= S_PEND;
              r_exc_pending <= 1'b1;
            end else begin
              r_state  <= S_FLUSH;
              r_flush  <= 1'b1;
              r_new_pc <= bus.exc_pc;
              r_fcnt   <= FC_LOAD;
            end
          end
        end
        S_PEND: begin
          if (!w_block) begin
            r_state       <= S_FLUSH;
            r_exc_pending <= 1'b0;
            r_flush       <= 1'b1;
            r_new_pc      <= r_pc;
            r_fcnt        <= FC_LOAD;
          end
        end
        S_FLUSH: begin
          if (r_fcnt == '0) begin
            r_state  <= S_IDLE;
            r_flush  <= 1'b0;
            r_new_pc <= '0;
          end else begin
            r_fcnt <= r_fcnt - FC_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
    end else if (bus.cnt_clr) begin
      r_stall_cycles <= '0;
    end else if (w_stall[0]) begin
      r_stall_cycles <= sat_inc(r_stall_cycles);
    end
  end

  assign bus.stall        = w_stall;
  assign bus.flush        = r_flush;
  assign bus.new_pc       = r_new_pc;
  assign bus.exc_pending  = r_exc_pending;
  assign bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipe_ctrl_param.sv
// Bench for pipe_ctrl_param: three builds (default, FLUSH_CYC=3, CNT_W=4) with
// directed scenarios plus randomized traffic against a behavioural model.
module tb_pipe_ctrl_param;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int          sel = 0;
  logic [4:0]  t_req = '0;
  logic        t_ev = 1'b0;
  logic [31:0] t_pc = '0;
  logic        t_clr = 1'b0;

  pipe_ctrl_if #(.NREQ(5), .STAGES(6), .PC_W(32), .CNT_W(32)) if0();
  pipe_ctrl_if #(.NREQ(5), .STAGES(6), .PC_W(32), .CNT_W(32)) if1();
  pipe_ctrl_if #(.NREQ(5), .STAGES(6), .PC_W(32), .CNT_W(4))  if2();

  assign if0.stall_req = (sel == 0) ? t_req : '0;
  assign if0.exc_valid = (sel == 0) ? t_ev  : 1'b0;
  assign if0.exc_pc    = (sel == 0) ? t_pc  : '0;
  assign if0.cnt_clr   = (sel == 0) ? t_clr : 1'b0;
  assign if1.stall_req = (sel == 1) ? t_req : '0;
  assign if1.exc_valid = (sel == 1) ? t_ev  : 1'b0;
  assign if1.exc_pc    = (sel == 1) ? t_pc  : '0;
  assign if1.cnt_clr   = (sel == 1) ? t_clr : 1'b0;
  assign if2.stall_req = (sel == 2) ? t_req : '0;
  assign if2.exc_valid = (sel == 2) ? t_ev  : 1'b0;
  assign if2.exc_pc    = (sel == 2) ? t_pc  : '0;
  assign if2.cnt_clr   = (sel == 2) ? t_clr : 1'b0;

  pipe_ctrl_param u0 (.clk(clk), .rst(rst), .bus(if0));
  pipe_ctrl_param #(.FLUSH_CYC(3)) u1 (.clk(clk), .rst(rst), .bus(if1));
  pipe_ctrl_param #(.CNT_W(4)) u2 (.clk(clk), .rst(rst), .bus(if2));

  logic [5:0]  o_stall;
  logic        o_flush;
  logic [31:0] o_npc;
  logic        o_pend;
  logic [31:0] o_cyc;

  always_comb begin
    case (sel)
      1: begin
        o_stall = if1.stall; o_flush = if1.flush; o_npc = if1.new_pc;
        o_pend = if1.exc_pending; o_cyc = if1.stall_cycles;
      end
      2: begin
        o_stall = if2.stall; o_flush = if2.flush; o_npc = if2.new_pc;
        o_pend = if2.exc_pending; o_cyc = {28'd0, if2.stall_cycles};
      end
      default: begin
        o_stall = if0.stall; o_flush = if0.flush; o_npc = if0.new_pc;
        o_pend = if0.exc_pending; o_cyc = if0.stall_cycles;
      end
    endcase
  end

  int errors = 0;
  int checks = 0;

  // Behavioural model: pending flag, remaining flush cycles, held pc, counter.
  logic [29:0] masks = {6'b000001, 6'b000101, 6'b001101, 6'b111111, 6'b111111};
  bit          m_pend;
  int          m_frem;
  logic [31:0] m_pc;
  longint      m_cnt;
  int          fc;
  longint      cmax;

  logic [5:0]  e_stall;
  logic        e_flush;
  logic [31:0] e_npc;
  logic        e_pend;
  logic [31:0] e_cyc;

  task automatic model_exp();
    e_flush = (m_frem > 0);
    e_npc   = e_flush ? m_pc : 32'd0;
    e_pend  = m_pend;
    e_cyc   = 32'(m_cnt);
    e_stall = '0;
    if (!rst && !e_flush) begin
      for (int i = 0; i < 5; i++) if (t_req[i]) e_stall = e_stall | masks[i*6 +: 6];
    end
  endtask

  task automatic tick();
    bit blk;
    model_exp();
    blk = t_req[1];
    if (t_clr) m_cnt = 0;
    else if (e_stall[0] && m_cnt < cmax) m_cnt = m_cnt + 1;
    if (m_frem > 0) m_frem = m_frem - 1;
    else if (m_pend) begin
      if (!blk) begin m_pend = 0; m_frem = fc; end
    end else if (t_ev) begin
      m_pc = t_pc;
      if (blk) m_pend = 1;
      else m_frem = fc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] req, input logic ev, input logic [31:0] pc,
                       input logic clr);
    t_req = req; t_ev = ev; t_pc = pc; t_clr = clr;
    #1;
  endtask

  task automatic do_reset(input int s);
    t_req = '0; t_ev = 1'b0; t_pc = '0; t_clr = 1'b0;
    sel  = s;
    fc   = (s == 1) ? 3 : 1;
    cmax = (s == 2) ? 64'd15 : 64'hFFFF_FFFF;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_pend = 0; m_frem = 0; m_pc = '0; m_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset(0);
    for (int k = 0; k < 3; k++) begin drive(5'b01000, 1'b0, 32'd0, 1'b0); tick(); end
    drive(5'b01010, 1'b1, 32'h1234, 1'b0);
    rst = 1'b1;
    #1;
    checks++; if (o_stall !== 6'd0) begin errors++; $display("FAIL reset_stall got=%b want=000000", o_stall); end
    checks++; if (o_flush !== 1'b0) begin errors++; $display("FAIL reset_flush got=%b want=0", o_flush); end
    checks++; if (o_npc !== 32'd0) begin errors++; $display("FAIL reset_new_pc got=%h want=0", o_npc); end
    checks++; if (o_pend !== 1'b0) begin errors++; $display("FAIL reset_pending got=%b want=0", o_pend); end
    checks++; if (o_cyc !== 32'd0) begin errors++; $display("FAIL reset_cycles got=%0d want=0", o_cyc); end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_stall_masks();
    logic [4:0] req [3] = '{5'b01000, 5'b11000, 5'b10001};
    logic [5:0] exp [3] = '{6'b000101, 6'b000101, 6'b111111};
    do_reset(0);
    for (int k = 0; k < 3; k++) begin
      drive(req[k], 1'b0, 32'd0, 1'b0);
      checks++;
      if (o_stall !== exp[k]) begin
        errors++; $display("FAIL stall_mask%0d got=%b want=%b", k, o_stall, exp[k]);
      end
      tick();
    end
    drive(5'b00000, 1'b0, 32'd0, 1'b0);
    checks++; if (o_cyc !== 32'd3) begin errors++; $display("FAIL stall_count got=%0d want=3", o_cyc); end
  endtask

  task automatic test_redirect();
    do_reset(0);
    drive(5'b00000, 1'b1, 32'hBFC00380, 1'b0);
    tick();
    drive(5'b01000, 1'b0, 32'd0, 1'b0);
    checks++; if (o_flush !== 1'b1) begin errors++; $display("FAIL redir_flush got=%b want=1", o_flush); end
    checks++; if (o_npc !== 32'hBFC00380) begin errors++; $display("FAIL redir_pc got=%h want=bfc00380", o_npc); end
    checks++; if (o_stall !== 6'd0) begin errors++; $display("FAIL redir_stall got=%b want=000000", o_stall); end
    tick();
    checks++; if (o_flush !== 1'b0) begin errors++; $display("FAIL redir_end got=%b want=0", o_flush); end
    checks++; if (o_npc !== 32'd0) begin errors++; $display("FAIL redir_pc_clr got=%h want=0", o_npc); end
    checks++; if (o_stall !== 6'b000101) begin errors++; $display("FAIL redir_stall_back got=%b want=000101", o_stall); end
  endtask

  task automatic test_deferred();
    do_reset(0);
    drive(5'b00010, 1'b1, 32'h80000180, 1'b0);
    checks++; if (o_pend !== 1'b0) begin errors++; $display("FAIL defer_c1 got=%b want=0", o_pend); end
    tick();
    for (int c = 2; c <= 5; c++) begin
      if (c == 5) drive(5'b00000, 1'b0, 32'd0, 1'b0);
      else drive(5'b00010, (c == 3), 32'h80000000, 1'b0);
      checks++;
      if (o_pend !== 1'b1 || o_flush !== 1'b0) begin
        errors++; $display("FAIL defer_c%0d pend=%b flush=%b want pend=1 flush=0", c, o_pend, o_flush);
      end
      tick();
    end
    drive(5'b00000, 1'b0, 32'd0, 1'b0);
    checks++; if (o_flush !== 1'b1) begin errors++; $display("FAIL defer_flush got=%b want=1", o_flush); end
    checks++; if (o_npc !== 32'h80000180) begin errors++; $display("FAIL defer_pc got=%h want=80000180", o_npc); end
    checks++; if (o_pend !== 1'b0) begin errors++; $display("FAIL defer_pend_clr got=%b want=0", o_pend); end
    tick();
    checks++; if (o_flush !== 1'b0) begin errors++; $display("FAIL defer_end got=%b want=0", o_flush); end
  endtask

  task automatic test_flush_len();
    do_reset(1);
    drive(5'b00000, 1'b1, 32'hA0000000, 1'b0);
    tick();
    for (int k = 1; k <= 5; k++) begin
      drive(5'b00000, (k <= 3), 32'(k), 1'b0);
      checks++;
      if (o_flush !== (k <= 3) || o_npc !== ((k <= 3) ? 32'hA0000000 : 32'd0)) begin
        errors++; $display("FAIL flush_len c%0d flush=%b pc=%h want flush=%b", k, o_flush, o_npc, (k <= 3));
      end
      tick();
    end
  endtask

  task automatic test_saturate();
    do_reset(2);
    for (int k = 0; k < 22; k++) begin
      drive(5'b10000, 1'b0, 32'd0, 1'b0);
      checks++;
      if (o_cyc !== ((k < 15) ? 32'(k) : 32'd15)) begin
        errors++; $display("FAIL sat_c%0d got=%0d want=%0d", k, o_cyc, (k < 15) ? k : 15);
      end
      tick();
    end
    drive(5'b10000, 1'b0, 32'd0, 1'b1);
    tick();
    drive(5'b10000, 1'b0, 32'd0, 1'b0);
    checks++; if (o_cyc !== 32'd0) begin errors++; $display("FAIL sat_clr got=%0d want=0", o_cyc); end
    drive(5'b00010, 1'b1, 32'h80000180, 1'b0);
    tick();
    drive(5'b00010, 1'b0, 32'd0, 1'b0);
    checks++; if (o_pend !== 1'b1) begin errors++; $display("FAIL sat_pend got=%b want=1", o_pend); end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (o_pend !== 1'b0 || o_flush !== 1'b0 || o_npc !== 32'd0 || o_stall !== 6'd0 || o_cyc !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_pend pend=%b flush=%b pc=%h stall=%b cyc=%0d want all 0",
               o_pend, o_flush, o_npc, o_stall, o_cyc);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_pend = 0; m_frem = 0; m_pc = '0; m_cnt = 0;
    drive(5'b00000, 1'b0, 32'd0, 1'b0);
    tick();
    checks++; if (o_flush !== 1'b0 || o_pend !== 1'b0) begin errors++; $display("FAIL rst_discard flush=%b pend=%b want 0", o_flush, o_pend); end
  endtask

  task automatic test_random();
    do_reset(0);
    for (int n = 0; n < 400; n++) begin
      drive(5'($urandom_range(0, 3) == 0 ? $urandom : 0) | ($urandom_range(0, 2) == 0 ? 5'b00010 : 5'b0),
            ($urandom_range(0, 3) == 0), $urandom, ($urandom_range(0, 19) == 0));
      model_exp();
      checks++;
      if (o_stall !== e_stall || o_flush !== e_flush || o_npc !== e_npc ||
          o_pend !== e_pend || o_cyc !== e_cyc) begin
        errors++;
        $display("FAIL rand_%0d got stall=%b flush=%b pc=%h pend=%b cyc=%0d want stall=%b flush=%b pc=%h pend=%b cyc=%0d",
                 n, o_stall, o_flush, o_npc, o_pend, o_cyc, e_stall, e_flush, e_npc, e_pend, e_cyc);
      end
      tick();
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_stall_masks();
    test_redirect();
    test_deferred();
    test_flush_len();
    test_saturate();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
